ymc_ctrl: RTL
=============

Name: ymc_ctrl

Overview:
- Multi-cycle control sequencer for the yIF/yID/yEX RISC-V datapath.
- Walks each instruction through FETCH, DECODE, EXEC, MEM and WB states, and drives the datapath control signals from the current state and the instruction fields.
- Counts retired instructions and halts on an all-zero word, an illegal opcode or a programmed instruction budget.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MAX_INS, 0, halt after this many retired instructions; 0 means unlimited.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin fetching.
- ins  input  32  current instruction word from the datapath instruction register.
- zero  input  1  ALU zero flag from yEX.
- IRWrite  output  1  load the instruction register.
- RegWrite  output  1  register-file write enable.
- ALUSrc  output  1  ALU B select: 1 = imm, 0 = rd2.
- op  output  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt.
- MemRead  output  1  data-memory read.
- MemWrite  output  1  data-memory write.
- Mem2Reg  output  1  write-data select: 1 = memory, 0 = ALU.
- Link  output  1  write-data select PCp4 (jal); overrides Mem2Reg.
- PCWrite  output  1  PC update strobe.
- PCSel  output  2  next-PC select: 00 PCp4, 01 branch, 10 jTarget.
- busy  output  1  high in any state other than IDLE or HALT.
- halted  output  1  high in HALT.
- illegal  output  1  sticky; unsupported opcode seen.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including retired and illegal.
  - Reset mid-instruction abandons it with no PCWrite and no RegWrite.
- State encoding: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Registered state; outputs decoded combinationally from state and ins.
- IDLE: moves to FETCH when start=1, otherwise holds.
- FETCH: IRWrite=1 for one cycle, then DECODE.
- DECODE: decodes ins[6:0], no side effects.
  - ins==0 goes to HALT without counting.
  - An opcode outside {33,13,03,23,63,6f} (hex) sets illegal and goes to HALT.
  - Otherwise goes to EXEC.
- EXEC, by opcode:
  - R (0x33): ALUSrc=0.
    - op by funct3/funct7: 000/0x00 add=010, 000/0x20 sub=110, 111 and=000, 110 or=001, 010 slt=111.
    - Any other combination is illegal and goes to HALT.
    - Next state WB.
  - I-ALU (0x13): ALUSrc=1, op as for R but funct7 is ignored (addi=010). Next state WB.
  - lw (0x03), sw (0x23): ALUSrc=1, op=010. Next state MEM.
  - beq (0x63): ALUSrc=0, op=110, PCWrite=1, PCSel=01 if zero=1 else 00. Instruction ends here.
  - jal (0x6f): next state WB.
- MEM:
  - lw: MemRead=1, ALUSrc=1, op=010 held. Next state WB.
  - sw: MemWrite=1, ALUSrc=1, op=010 held, PCWrite=1, PCSel=00. Instruction ends here.
- WB:
  - RegWrite=1 and PCWrite=1.
  - R/I: Mem2Reg=0, ALU controls held from EXEC, PCSel=00.
  - lw: Mem2Reg=1, PCSel=00.
  - jal: Link=1, PCSel=10.
- Instruction latency is fixed: R/I 4, lw 5, sw 4, beq 3, jal 4 cycles.
- PCWrite is asserted exactly once per instruction, in its final state.
- Retirement:
  - retired increments on the final-state cycle and wraps modulo 2^CNT_W.
  - Next state is FETCH, unless MAX_INS != 0 and the new count equals MAX_INS, in which case it is HALT.
- HALT is sticky until reset; start is ignored.
- Default for every control output in any state not listed: 0. op defaults to 010.
- RegWrite is never asserted for sw or beq. MemRead and MemWrite are never both 1.

Test Plan:
- Reset, start=1, ins=0x002081B3 (add x3,x1,x2):
  - States run FETCH, DECODE, EXEC, WB.
  - EXEC: op=010, ALUSrc=0.
  - WB: RegWrite=1, PCWrite=1, PCSel=00; retired=1.
- ins=0x402081B3 (sub): op=110 in EXEC. Then ins=0x0000A283 (lw x5,0(x1)): 5 cycles, MemRead=1 in MEM, Mem2Reg=1 and RegWrite=1 in WB.
- ins=0x0050A223 (sw x5,4(x1)):
  - MEM: MemWrite=1, PCWrite=1, RegWrite=0.
  - 4 cycles total.
- ins=0x00208463 (beq x1,x2,8):
  - zero=1: PCSel=01 in EXEC.
  - zero=0: PCSel=00.
  - 3 cycles, RegWrite=0 throughout.
- ins=0x008000EF (jal x1,8): WB has Link=1, RegWrite=1, PCSel=10. Then ins=0x0000007F: illegal=1 and halted=1 after DECODE, retired unchanged.
- MAX_INS=3, 4 adds: halted after the 3rd WB, retired=3. Separately, pulse rst_n low during MEM of a lw: outputs 0 immediately, state IDLE, no PCWrite.

Source files
------------

// File: rtl/ymc_ctrl.sv
// ymc_ctrl: multi-cycle control sequencer for the yIF/yID/yEX RISC-V datapath.
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The datapath
// controls are decoded combinationally from the current state and ins.
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            leave IDLE and begin fetching
//   ins[31:0]        instruction word held in the datapath IR
//   zero             ALU zero flag, used by beq
//   IRWrite .. PCSel datapath control strobes and selects
//   busy, halted     sequencer status
//   illegal          sticky: an unsupported instruction was seen
//   retired          retired-instruction count, wraps modulo 2^CNT_W
module ymc_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MAX_INS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      ins,
  input  logic             zero,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic [2:0]       op,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Mem2Reg,
  output logic             Link,
  output logic             PCWrite,
  output logic [1:0]       PCSel,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LW  = 7'h03;
  localparam logic [6:0] OPC_SW  = 7'h23;
  localparam logic [6:0] OPC_BEQ = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6f;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Returns {legal, op}. funct7 is only checked for R-type (use_f7=1); an
  // illegal combination reports op=add so op never leaves its default.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic       use_f7);
    logic       f7_zero;
    logic [3:0] res;
    f7_zero = !use_f7 || (f7 == 7'h00);
    res     = {1'b0, ALU_ADD};
    case (f3)
      3'b000: begin
        if (f7_zero) res = {1'b1, ALU_ADD};
        else if (f7 == 7'h20) res = {1'b1, ALU_SUB};
        else res = {1'b0, ALU_ADD};
      end
      3'b111: res = f7_zero ? {1'b1, ALU_AND} : {1'b0, ALU_ADD};
      3'b110: res = f7_zero ? {1'b1, ALU_OR}  : {1'b0, ALU_ADD};
      3'b010: res = f7_zero ? {1'b1, ALU_SLT} : {1'b0, ALU_ADD};
      default: res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             retire_s;
  logic [6:0]       opcode_s;
  logic [3:0]       alu_s;
  logic             opc_legal_s;
  logic             unused_s;

  logic       irwrite_s, regwrite_s, alusrc_s, memread_s, memwrite_s;
  logic       mem2reg_s, link_s, pcwrite_s, busy_s, halted_s;
  logic [2:0] op_s;
  logic [1:0] pcsel_s;

  assign opcode_s    = ins[6:0];
  assign alu_s       = alu_decode(ins[14:12], ins[31:25], opcode_s == OPC_R);
  assign opc_legal_s = (opcode_s == OPC_R)  || (opcode_s == OPC_I)   ||
                       (opcode_s == OPC_LW) || (opcode_s == OPC_SW)  ||
                       (opcode_s == OPC_BEQ)|| (opcode_s == OPC_JAL);
  // Register numbers and immediates belong to the datapath, not the sequencer.
  assign unused_s    = ^{ins[24:15], ins[11:7]};

  // Next-state, control decode and retirement bookkeeping.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    retired_d  = retired_q;
    retire_s   = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    alusrc_s   = 1'b0;
    op_s       = ALU_ADD;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    mem2reg_s  = 1'b0;
    link_s     = 1'b0;
    pcwrite_s  = 1'b0;
    pcsel_s    = 2'b00;
    busy_s     = 1'b1;
    halted_s   = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_s = 1'b0;
        op_s   = 3'b000;   // everything reads 0 while idle / in reset
        if (start) state_d = S_FETCH;
        else state_d = S_IDLE;
      end
      S_FETCH: begin
        irwrite_s = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (ins == 32'h0000_0000) begin
          state_d = S_HALT;
        end else if (!opc_legal_s) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode_s)
          OPC_R, OPC_I: begin
            alusrc_s = (opcode_s == OPC_I);
            op_s     = alu_s[2:0];
            if (alu_s[3]) begin
              state_d = S_WB;
            end else begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          end
          OPC_LW, OPC_SW: begin
            alusrc_s = 1'b1;
            state_d  = S_MEM;
          end
          OPC_BEQ: begin
            op_s      = ALU_SUB;
            pcwrite_s = 1'b1;
            pcsel_s   = zero ? 2'b01 : 2'b00;
            retire_s  = 1'b1;
          end
          OPC_JAL: state_d = S_WB;
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        alusrc_s = 1'b1;
        case (opcode_s)
          OPC_LW: begin
            memread_s = 1'b1;
            state_d   = S_WB;
          end
          OPC_SW: begin
            memwrite_s = 1'b1;
            pcwrite_s  = 1'b1;
            retire_s   = 1'b1;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        endcase
      end
      S_WB: begin
        regwrite_s = 1'b1;
        pcwrite_s  = 1'b1;
        retire_s   = 1'b1;
        case (opcode_s)
          OPC_R, OPC_I: begin
            alusrc_s = (opcode_s == OPC_I);
            op_s     = alu_s[2:0];
          end
          OPC_LW:  mem2reg_s = 1'b1;
          OPC_JAL: begin
            link_s  = 1'b1;
            pcsel_s = 2'b10;
          end
          default: mem2reg_s = 1'b0;
        endcase
      end
      S_HALT: begin
        busy_s   = 1'b0;
        halted_s = 1'b1;
        op_s     = 3'b000;
        state_d  = S_HALT;
      end
      default: begin
        busy_s  = 1'b0;
        op_s    = 3'b000;
        state_d = S_IDLE;
      end
    endcase

    // The final-state cycle of every instruction retires it; the budget
    // check uses the post-increment count.
    if (retire_s) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if ((MAX_INS != 0) && (retired_d == CNT_W'(MAX_INS))) state_d = S_HALT;
      else state_d = S_FETCH;
    end else begin
      retired_d = retired_q;
    end
  end

  // State, sticky illegal flag and retired counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign IRWrite  = irwrite_s;
  assign RegWrite = regwrite_s;
  assign ALUSrc   = alusrc_s;
  assign op       = op_s;
  assign MemRead  = memread_s;
  assign MemWrite = memwrite_s;
  assign Mem2Reg  = mem2reg_s;
  assign Link     = link_s;
  assign PCWrite  = pcwrite_s;
  assign PCSel    = pcsel_s;
  assign busy     = busy_s;
  assign halted   = halted_s;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule
